// File: rtl/rst_pkg.sv
// Shared types and constants for the register status table.
// Default geometry, entry layout and next-state priority codes.
package rst_pkg;

  localparam int RST_NUM_REGS = 32;
  localparam int RST_TAG_W    = 5;
  localparam int RST_NUM_RD   = 2;
  localparam int RST_NUM_CDB  = 2;
  localparam int RST_NUM_CKPT = 4;

  function automatic int ck_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [RST_TAG_W-1:0] tag;
  } rst_entry_t;

  typedef enum logic [1:0] {
    PRI_NORM  = 2'd0,
    PRI_REST  = 2'd1,
    PRI_FLUSH = 2'd2
  } rst_pri_e;

endpackage

// File: rtl/rst_ckpt_if.sv
// Dispatch/CDB/checkpoint bundle between issue logic and the status table.
// master = issue side, slave = table.
interface rst_ckpt_if
  import rst_pkg::*;
#(
  parameter int NUM_REGS = RST_NUM_REGS,
  parameter int TAG_W    = RST_TAG_W,
  parameter int NUM_RD   = RST_NUM_RD,
  parameter int NUM_CDB  = RST_NUM_CDB,
  parameter int NUM_CKPT = RST_NUM_CKPT
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CK_W   = ck_w(NUM_CKPT);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [TAG_W-1:0]         wr_tag;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_REGS-1:0]      clr_vec;
  logic                     flush;
  logic                     ckpt_save;
  logic [CK_W-1:0]          ckpt_save_id;
  logic                     ckpt_rest;
  logic [CK_W-1:0]          ckpt_rest_id;
  logic                     ckpt_free;
  logic [CK_W-1:0]          ckpt_free_id;
  logic [NUM_CKPT-1:0]      ckpt_live;
  logic                     ckpt_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_tag,
    output cdb_valid, cdb_tag, flush,
    output ckpt_save, ckpt_save_id,
    output ckpt_rest, ckpt_rest_id,
    output ckpt_free, ckpt_free_id,
    input  rd_tag, rd_valid, clr_vec,
    input  ckpt_live, ckpt_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_tag,
    input  cdb_valid, cdb_tag, flush,
    input  ckpt_save, ckpt_save_id,
    input  ckpt_rest, ckpt_rest_id,
    input  ckpt_free, ckpt_free_id,
    output rd_tag, rd_valid, clr_vec,
    output ckpt_live, ckpt_err
  );

endinterface

// File: rtl/rst_cdb_match.sv
// Flags every pending entry of one table image whose tag
// is broadcast on any valid CDB channel (full-tag compare).
module rst_cdb_match #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 5,
  parameter int NUM_CDB  = 2
) (
  input  logic [NUM_REGS-1:0]            valid_i,
  input  logic [NUM_REGS-1:0][TAG_W-1:0] tag_i,
  input  logic [NUM_CDB-1:0]             cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]       cdb_tag_i,
  output logic [NUM_REGS-1:0]            clr_o
);

  always_comb begin
    clr_o = '0;
    for (int e = 0; e < NUM_REGS; e++) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (valid_i[e] && cdb_valid_i[c] &&
            tag_i[e] == cdb_tag_i[c*TAG_W +: TAG_W])
          clr_o[e] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_ckpt.sv
// Register status table with CDB clears and branch checkpoints.
// Live slots track CDB clears so a restore never revives a retired tag.
module rst_ckpt
  import rst_pkg::*;
#(
  parameter int NUM_REGS  = RST_NUM_REGS,
  parameter int TAG_W     = RST_TAG_W,
  parameter int NUM_RD    = RST_NUM_RD,
  parameter int NUM_CDB   = RST_NUM_CDB,
  parameter int NUM_CKPT  = RST_NUM_CKPT,
  parameter bit ZERO_HARD = 1'b1
) (
  input logic         clock,
  input logic         reset,
  rst_ckpt_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef logic [NUM_REGS-1:0]            vld_t;
  typedef logic [NUM_REGS-1:0][TAG_W-1:0] tags_t;

  vld_t                 vld_q, vld_d;
  tags_t                tag_q, tag_d;
  vld_t  [NUM_CKPT-1:0] sv_q, sv_d;
  tags_t [NUM_CKPT-1:0] st_q, st_d;
  logic  [NUM_CKPT-1:0] live_q, live_d;
  logic                 err_q, err_d;

  vld_t                 m_live;
  vld_t  [NUM_CKPT-1:0] m_slot;
  vld_t                 wr_dec;
  vld_t                 clr;
  logic                 wr_ok;
  rst_pri_e             pri;

  rst_cdb_match #(
    .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
  ) u_live (
    .valid_i    (vld_q),
    .tag_i      (tag_q),
    .cdb_valid_i(bus.cdb_valid),
    .cdb_tag_i  (bus.cdb_tag),
    .clr_o      (m_live)
  );

  for (genvar k = 0; k < NUM_CKPT; k++) begin : g_slot
    rst_cdb_match #(
      .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)
    ) u_slot (
      .valid_i    (sv_q[k]),
      .tag_i      (st_q[k]),
      .cdb_valid_i(bus.cdb_valid),
      .cdb_tag_i  (bus.cdb_tag),
      .clr_o      (m_slot[k])
    );
  end

  always_comb begin
    wr_dec = '0;
    if (bus.wr_en)
      wr_dec[bus.wr_addr] = 1'b1;
  end

  assign clr   = m_live & ~wr_dec;
  assign wr_ok = bus.wr_en &&
                 !(ZERO_HARD && bus.wr_addr == '0);

  always_comb begin
    pri = PRI_NORM;
    if (bus.flush)
      pri = PRI_FLUSH;
    else if (bus.ckpt_rest && live_q[bus.ckpt_rest_id])
      pri = PRI_REST;
  end

  always_comb begin
    vld_d  = vld_q & ~clr;
    tag_d  = tag_q;
    live_d = live_q;
    err_d  = 1'b0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      sv_d[k] = sv_q[k] & ~m_slot[k];
      st_d[k] = st_q[k];
    end
    if (wr_ok) begin
      vld_d[bus.wr_addr] = 1'b1;
      tag_d[bus.wr_addr] = bus.wr_tag;
    end
    unique case (pri)
      PRI_FLUSH: begin
        vld_d  = '0;
        tag_d  = tag_q;
        live_d = '0;
        sv_d   = '0;
      end
      PRI_REST: begin
        vld_d = sv_q[bus.ckpt_rest_id] &
                ~m_slot[bus.ckpt_rest_id];
        tag_d = st_q[bus.ckpt_rest_id];
        err_d = bus.ckpt_save;
        if (bus.ckpt_free)
          live_d[bus.ckpt_free_id] = 1'b0;
      end
      default: begin
        // any restore reaching here targeted a dead slot
        err_d = bus.ckpt_rest;
        if (bus.ckpt_free)
          live_d[bus.ckpt_free_id] = 1'b0;
        if (bus.ckpt_save) begin
          live_d[bus.ckpt_save_id] = 1'b1;
          sv_d[bus.ckpt_save_id]   = vld_d;
          st_d[bus.ckpt_save_id]   = tag_d;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      tag_q  <= '0;
      sv_q   <= '0;
      st_q   <= '0;
      live_q <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      sv_q   <= sv_d;
      st_q   <= st_d;
      live_q <= live_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.rd_tag   = '0;
    bus.rd_valid = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_tag[p*TAG_W +: TAG_W] =
        tag_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
      bus.rd_valid[p] =
        vld_q[bus.rd_addr[p*ADDR_W +: ADDR_W]] &
        ~m_live[bus.rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  assign bus.clr_vec   = clr;
  assign bus.ckpt_live = live_q;
  assign bus.ckpt_err  = err_q;

endmodule

// File: tb/tb_rst_ckpt.sv
// Directed vector bench for rst_ckpt.
// Inputs change on negedge; outputs sampled 2 ns later.
module tb_rst_ckpt;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;

  rst_ckpt_if bus ();

  rst_ckpt dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  wt;
    logic [1:0]  cv;
    logic [4:0]  ct0;
    logic [4:0]  ct1;
    logic        fl;
    logic        sv;
    logic [1:0]  sid;
    logic        rs;
    logic [1:0]  rid;
    logic        fr;
    logic [1:0]  fid;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ev0;
    logic [4:0]  et0;
    logic        ev1;
    logic [4:0]  et1;
    logic [31:0] eclr;
    logic [3:0]  elive;
    logic        eerr;
  } vec_t;

  localparam int NV = 35;
  vec_t tv [NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en        = v.we;
    bus.wr_addr      = v.wa;
    bus.wr_tag       = v.wt;
    bus.cdb_valid    = v.cv;
    bus.cdb_tag      = {v.ct1, v.ct0};
    bus.flush        = v.fl;
    bus.ckpt_save    = v.sv;
    bus.ckpt_save_id = v.sid;
    bus.ckpt_rest    = v.rs;
    bus.ckpt_rest_id = v.rid;
    bus.ckpt_free    = v.fr;
    bus.ckpt_free_id = v.fid;
    bus.rd_addr      = {v.ra1, v.ra0};
  endtask

  task automatic idle(input logic [4:0] ra0);
    vec_t v;
    v = '{0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,0, 0, 0,0};
    v.ra0 = ra0;
    drive(v);
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    idle(5'd5);

    // fields: we wa wt | cv ct0 ct1 | fl sv sid rs rid fr fid |
    //         ra0 ra1 | ev0 et0 ev1 et1 | clr | live err
    tv[0]  = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 5,0, 0,0,0,0,   0,     0,0};
    tv[1]  = '{1,5,9,  0,0,0,  0,0,0,0,0,0,0, 5,0, 0,0,0,0,   0,     0,0};
    tv[2]  = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 5,0, 1,9,0,0,   0,     0,0};
    tv[3]  = '{0,0,0,  1,9,0,  0,0,0,0,0,0,0, 5,0, 0,9,0,0,   32'h20,0,0};
    tv[4]  = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 5,0, 0,9,0,0,   0,     0,0};
    tv[5]  = '{1,5,9,  0,0,0,  0,0,0,0,0,0,0, 5,0, 0,9,0,0,   0,     0,0};
    tv[6]  = '{1,5,12, 2,0,9,  0,0,0,0,0,0,0, 5,0, 0,9,0,0,   0,     0,0};
    tv[7]  = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 5,0, 1,12,0,0,  0,     0,0};
    tv[8]  = '{0,0,0,  1,13,0, 0,0,0,0,0,0,0, 5,0, 1,12,0,0,  0,     0,0};
    tv[9]  = '{0,0,0,  0,12,0, 0,0,0,0,0,0,0, 5,0, 1,12,0,0,  0,     0,0};
    tv[10] = '{1,3,4,  0,0,0,  0,0,0,0,0,0,0, 3,5, 0,0,1,12,  0,     0,0};
    tv[11] = '{0,0,0,  0,0,0,  0,1,1,0,0,0,0, 3,0, 1,4,0,0,   0,     0,0};
    tv[12] = '{1,3,7,  0,0,0,  0,0,0,0,0,0,0, 3,0, 1,4,0,0,   0,     2,0};
    tv[13] = '{0,0,0,  1,4,0,  0,0,0,0,0,0,0, 3,0, 1,7,0,0,   0,     2,0};
    tv[14] = '{0,0,0,  0,0,0,  0,0,0,1,1,0,0, 3,5, 1,7,1,12,  0,     2,0};
    tv[15] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 3,5, 0,4,1,12,  0,     2,0};
    tv[16] = '{1,7,3,  0,0,0,  0,0,0,1,2,0,0, 7,0, 0,0,0,0,   0,     2,0};
    tv[17] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 7,0, 1,3,0,0,   0,     2,1};
    tv[18] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 7,0, 1,3,0,0,   0,     2,0};
    tv[19] = '{1,9,1,  0,0,0,  0,1,2,1,1,0,0, 9,0, 0,0,0,0,   0,     2,0};
    tv[20] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 9,5, 0,0,1,12,  0,     2,1};
    tv[21] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 7,0, 0,0,0,0,   0,     2,0};
    tv[22] = '{0,0,0,  0,0,0,  0,1,3,0,0,1,3, 0,0, 0,0,0,0,   0,     2,0};
    tv[23] = '{0,0,0,  0,0,0,  0,0,0,0,0,1,1, 0,0, 0,0,0,0,   0,     10,0};
    tv[24] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0,0,0,   0,     8,0};
    tv[25] = '{1,1,2,  0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0,0,0,   0,     8,0};
    tv[26] = '{1,8,6,  0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0,0,0,   0,     8,0};
    tv[27] = '{0,0,0,  3,2,6,  0,0,0,0,0,0,0, 1,8, 0,2,0,6,   32'h102,8,0};
    tv[28] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 1,8, 0,2,0,6,   0,     8,0};
    tv[29] = '{1,0,5,  0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0,0,0,   0,     8,0};
    tv[30] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0,0,0,   0,     8,0};
    tv[31] = '{1,2,3,  0,0,0,  0,0,0,0,0,0,0, 2,0, 0,0,0,0,   0,     8,0};
    tv[32] = '{1,4,1,  0,0,0,  1,1,0,0,0,0,0, 2,0, 1,3,0,0,   0,     8,0};
    tv[33] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 2,5, 0,3,0,12,  0,     0,0};
    tv[34] = '{0,0,0,  0,0,0,  0,0,0,0,0,0,0, 4,0, 0,0,0,0,   0,     0,0};

    repeat (2) @(negedge clk);
    #2;
    chk("rst live", 32'(bus.ckpt_live), 32'h0);
    chk("rst err", 32'(bus.ckpt_err), 32'h0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      chk($sformatf("v%0d rd_valid0", i),
          32'(bus.rd_valid[0]), 32'(tv[i].ev0));
      chk($sformatf("v%0d rd_tag0", i),
          32'(bus.rd_tag[4:0]), 32'(tv[i].et0));
      chk($sformatf("v%0d rd_valid1", i),
          32'(bus.rd_valid[1]), 32'(tv[i].ev1));
      chk($sformatf("v%0d rd_tag1", i),
          32'(bus.rd_tag[9:5]), 32'(tv[i].et1));
      chk($sformatf("v%0d clr_vec", i),
          bus.clr_vec, tv[i].eclr);
      chk($sformatf("v%0d ckpt_live", i),
          32'(bus.ckpt_live), 32'(tv[i].elive));
      chk($sformatf("v%0d ckpt_err", i),
          32'(bus.ckpt_err), 32'(tv[i].eerr));
    end

    // save to slot 0 while restoring dead slot 2: save proceeds, err pulses
    @(negedge clk);
    drive('{1,6,11, 0,0,0, 0,1,0,1,2,0,0, 6,0,
            0,0,0,0, 0, 0,0});
    @(negedge clk);
    idle(5'd6);
    #2;
    chk("pre-rst rd_valid0", 32'(bus.rd_valid[0]), 32'h1);
    chk("pre-rst rd_tag0", 32'(bus.rd_tag[4:0]), 32'd11);
    chk("pre-rst live", 32'(bus.ckpt_live), 32'h1);
    chk("pre-rst err", 32'(bus.ckpt_err), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rd_valid0", 32'(bus.rd_valid[0]), 32'h0);
    chk("async rd_tag0", 32'(bus.rd_tag[4:0]), 32'h0);
    chk("async live", 32'(bus.ckpt_live), 32'h0);
    chk("async err", 32'(bus.ckpt_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("post-rst rd_valid0", 32'(bus.rd_valid[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
